gsim_solver: RTL

- Parametrised iterative Gauss-Seidel solver for the banded N-unknown system with coefficients (20, -13, 6, -1) on diagonals 0, ±1, ±2, ±3.
- Accepts b_0..b_{N-1} as a stream, runs a programmable number of in-place sweeps through a 2-stage datapath, then streams x_0..x_{N-1} out under valid/ready.
- Next generation of the fixed 16-unknown, 100-run solver: adds configurable size, formats and iteration count, input/output handshakes, and an optional convergence exit.

---
 rtl/gsim_pkg.sv | 22 ++
 rtl/gsim_div20.sv | 25 ++
 rtl/gsim_solver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared types and constants for the banded Gauss-Seidel solver
package gsim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  // round(2^32 / 20): x = S/20 becomes a multiply and a 32-bit shift
  localparam logic [31:0] RECIP = 32'd214748365;

  localparam int C1 = 13;
  localparam int C2 = 6;
  localparam int C3 = 1;

  // sum register is X_W + SUM_GUARD bits wide
  localparam int SUM_GUARD = 6;

endpackage

// File: rtl/gsim_div20.sv
// rtl/gsim_div20.sv - combinational divide-by-20 of the registered sum, round half up
module gsim_div20
  import gsim_pkg::*;
#(
  parameter int X_W = 32
) (
  input  logic signed [X_W+SUM_GUARD-1:0] s_reg,
  output logic signed [X_W-1:0]           x_new
);

  localparam int SW = X_W + SUM_GUARD;
  localparam int PW = SW + 30;

  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] r_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;

  assign s_ext = {{(PW-SW){s_reg[SW-1]}}, s_reg};
  assign r_ext = {{(PW-32){1'b0}}, RECIP};
  assign prod  = s_ext * r_ext;
  assign rnd   = prod + {{(PW-32){1'b0}}, 32'h8000_0000};
  assign x_new = X_W'(rnd >>> 32);

endmodule

// File: rtl/gsim_solver.sv
// rtl/gsim_solver.sv - streaming Gauss-Seidel solver, coefficients (20,-13,6,-1)
// Optional early exit on convergence with GSIM_CONV_EN.
module gsim_solver
  import gsim_pkg::*;
#(
  parameter int N    = 16,
  parameter int B_W  = 16,
  parameter int X_W  = 32,
  parameter int FRAC = 16,
  parameter int IT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_en,
  input  logic signed [B_W-1:0]  b_in,
  input  logic [IT_W-1:0]        iter_num,
  input  logic [X_W-1:0]         conv_tol,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [X_W-1:0]         x_out,
  output logic [IT_W-1:0]        iters_used
);

  localparam int SW    = X_W + SUM_GUARD;
  localparam int IDX_W = $clog2(N);
  localparam logic signed [SW-1:0] K1 = SW'(C1);
  localparam logic signed [SW-1:0] K2 = SW'(C2);
  localparam logic signed [SW-1:0] K3 = SW'(C3);

  state_t                  state;
  logic [IDX_W-1:0]        load_idx, issue_idx, s_idx, out_idx;
  logic [IT_W-1:0]         iter_tgt, sweep_cnt;
  logic signed [SW-1:0]    s_reg, sum, b_ext;
  logic signed [SW-1:0]    xm1, xm2, xm3, xp1, xp2, xp3;
  logic                    s_valid;
  logic signed [B_W-1:0]   b_mem [N];
  logic signed [X_W-1:0]   x_mem [N];
  logic signed [X_W-1:0]   x_new;
  logic                    accept, last_idx, last_sweep, conv_hit, sweep_done;
  int                      ii;

  function automatic logic signed [SW-1:0] sx(input logic signed [X_W-1:0] v);
    return SW'(v);
  endfunction

  assign accept     = in_en && in_ready;
  assign last_idx   = (issue_idx == IDX_W'(N-1));
  assign last_sweep = (sweep_cnt == iter_tgt - 1'b1);
  assign sweep_done = last_sweep || conv_hit;

  gsim_div20 #(.X_W(X_W)) u_div (
    .s_reg (s_reg),
    .x_new (x_new)
  );

  // x_{i-1} is still in the divider when i issues, so it is taken from x_new
  always_comb begin
    ii    = int'(issue_idx);
    b_ext = SW'(b_mem[issue_idx]) <<< FRAC;
    xm1   = (ii >= 1)    ? sx(x_new)                  : '0;
    xm2   = (ii >= 2)    ? sx(x_mem[IDX_W'(ii - 2)])  : '0;
    xm3   = (ii >= 3)    ? sx(x_mem[IDX_W'(ii - 3)])  : '0;
    xp1   = (ii + 1 < N) ? sx(x_mem[IDX_W'(ii + 1)])  : '0;
    xp2   = (ii + 2 < N) ? sx(x_mem[IDX_W'(ii + 2)])  : '0;
    xp3   = (ii + 3 < N) ? sx(x_mem[IDX_W'(ii + 3)])  : '0;
    sum   = b_ext + K1 * (xm1 + xp1) - K2 * (xm2 + xp2) + K3 * (xm3 + xp3);
  end

`ifdef GSIM_CONV_EN
  logic [X_W:0]        d_reg, d_cur, d_eff;
  logic signed [X_W:0] diff;

  always_comb begin
    diff  = {x_new[X_W-1], x_new} - {x_mem[s_idx][X_W-1], x_mem[s_idx]};
    d_cur = '0;
    if (s_valid) d_cur = diff[X_W] ? (-diff) : diff;
    d_eff = (d_cur > d_reg) ? d_cur : d_reg;
  end
  assign conv_hit = (d_eff <= {1'b0, conv_tol});
`else
  logic unused_conv_tol;
  assign unused_conv_tol = ^conv_tol;
  assign conv_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        b_mem[load_idx] <= b_in;
        if (state == ST_IDLE) begin
          for (int k = 0; k < N; k++) x_mem[k] <= '0;
        end
      end
      if (s_valid) x_mem[s_idx] <= x_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      x_out      <= '0;
      iters_used <= '0;
      s_valid    <= 1'b0;
      s_reg      <= '0;
      s_idx      <= '0;
      load_idx   <= '0;
      issue_idx  <= '0;
      out_idx    <= '0;
      iter_tgt   <= '0;
      sweep_cnt  <= '0;
`ifdef GSIM_CONV_EN
      d_reg      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            load_idx  <= IDX_W'(1);
            iter_tgt  <= (iter_num == '0) ? IT_W'(1) : iter_num;
            sweep_cnt <= '0;
            issue_idx <= '0;
`ifdef GSIM_CONV_EN
            d_reg     <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (load_idx == IDX_W'(N-1)) begin
              state    <= ST_SWEEP;
              in_ready <= 1'b0;
              load_idx <= '0;
            end else begin
              load_idx <= load_idx + 1'b1;
            end
          end
        end
        ST_SWEEP: begin
          s_reg   <= sum;
          s_valid <= 1'b1;
          s_idx   <= issue_idx;
`ifdef GSIM_CONV_EN
          d_reg   <= last_idx ? '0 : d_eff;
`endif
          if (last_idx) begin
            issue_idx <= '0;
            if (sweep_done) begin
              state      <= ST_DRAIN;
              iters_used <= sweep_cnt + 1'b1;
            end else begin
              sweep_cnt <= sweep_cnt + 1'b1;
            end
          end else begin
            issue_idx <= issue_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          s_valid   <= 1'b0;
          state     <= ST_OUTPUT;
          out_valid <= 1'b1;
          x_out     <= x_mem[0];
          out_idx   <= '0;
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            if (out_idx == IDX_W'(N-1)) begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_idx <= out_idx + 1'b1;
              x_out   <= x_mem[out_idx + 1'b1];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
